// File: rtl/moody_pkg.sv
// moody_pkg: definitions shared by the emotion regulators.
//   reg_state_t      regulator state (IDLE, COOLDOWN)
//   DEFAULT_*        default sizing and threshold constants
//   popcount16()     count of set bits in a 16-bit vector
//   cnt_width()      counter width able to hold 0..max_val, never below 1
package moody_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    COOLDOWN = 1'b1
  } reg_state_t;

  localparam int DEFAULT_NUM_STIMULI    = 7;
  localparam int DEFAULT_ACC_WIDTH      = 8;
  localparam int DEFAULT_INC_THRESHOLD  = 16;
  localparam int DEFAULT_QUIET_TICKS    = 8;
  localparam int DEFAULT_COOLDOWN_TICKS = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  // A zero-length counter is not legal, so a zero maximum still gets one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stimulus_popcount.sv
// stimulus_popcount: combinational count of active stimulus flags.
//   stimuli  in   NUM_STIMULI  active-high flags, each weight 1
//   count    out  clog2(N+1)   number of flags set
module stimulus_popcount
  import moody_pkg::*;
#(
  parameter int NUM_STIMULI = DEFAULT_NUM_STIMULI
) (
  input  logic [NUM_STIMULI-1:0]         stimuli,
  output logic [$clog2(NUM_STIMULI+1)-1:0] count
);

  localparam int CNT_W = $clog2(NUM_STIMULI + 1);

  // NUM_STIMULI is at most 15, so widening to 16 bits never drops a flag.
  assign count = CNT_W'(popcount16(16'(stimuli)));

endmodule

// File: rtl/stress_accumulator.sv
// stress_accumulator: integrates binary stimuli into a leaky, saturating
// level and emits rate-limited single-cycle inc/dec pulses, merged with
// sleep-controller override requests. State advances only when tick=1.
//   clk, rst_n            clock; synchronous active-low reset
//   tick                  evaluation enable
//   sleep_controller_inc  override request for an inc pulse
//   sleep_controller_dec  override request for a dec pulse
//   stimuli               active-high stimulus flags
//   stress_inc/dec        registered one-clock pulses
//   level                 current accumulator value
//   busy                  high while in COOLDOWN
module stress_accumulator
  import moody_pkg::*;
#(
  parameter int NUM_STIMULI    = DEFAULT_NUM_STIMULI,
  parameter int ACC_WIDTH      = DEFAULT_ACC_WIDTH,
  parameter int INC_THRESHOLD  = DEFAULT_INC_THRESHOLD,
  parameter int QUIET_TICKS    = DEFAULT_QUIET_TICKS,
  parameter int COOLDOWN_TICKS = DEFAULT_COOLDOWN_TICKS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   sleep_controller_inc,
  input  logic                   sleep_controller_dec,
  input  logic [NUM_STIMULI-1:0] stimuli,
  output logic                   stress_inc,
  output logic                   stress_dec,
  output logic [ACC_WIDTH-1:0]   level,
  output logic                   busy
);

  localparam int CNT_W = $clog2(NUM_STIMULI + 1);
  // Sum width covers level+p even when p can exceed the accumulator range.
  localparam int SUM_W = ((ACC_WIDTH > CNT_W) ? ACC_WIDTH : CNT_W) + 1;
  localparam int Q_W   = cnt_width(QUIET_TICKS);
  localparam int CD_W  = cnt_width(COOLDOWN_TICKS);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX   = '1;
  localparam logic [ACC_WIDTH-1:0] THRESH    = ACC_WIDTH'(INC_THRESHOLD);
  localparam logic [Q_W-1:0]       QUIET_MAX = Q_W'(QUIET_TICKS);
  localparam logic [CD_W-1:0]      CD_LOAD   = CD_W'(COOLDOWN_TICKS);

  reg_state_t           state_q, state_d;
  logic [ACC_WIDTH-1:0] level_q, level_d, acc_next;
  logic [Q_W-1:0]       quiet_q, quiet_d, quiet_next;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 inc_q, dec_q, inc_d, dec_d;
  logic [CNT_W-1:0]     pop;
  logic [SUM_W-1:0]     sum;

  stimulus_popcount #(.NUM_STIMULI(NUM_STIMULI)) u_popcount (
    .stimuli (stimuli),
    .count   (pop)
  );

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sum        = SUM_W'(level_q) + SUM_W'(pop);
    acc_next   = level_q;
    quiet_next = quiet_q;
    level_d    = level_q;
    quiet_d    = quiet_q;
    cd_d       = cd_q;
    state_d    = state_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;

    // Saturating rise on any activity, one-per-tick leak when quiet.
    if (pop != '0) begin
      acc_next   = (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_WIDTH-1:0];
      quiet_next = '0;
    end else begin
      acc_next   = (level_q != '0) ? level_q - ACC_WIDTH'(1) : '0;
      quiet_next = (quiet_q < QUIET_MAX) ? quiet_q + Q_W'(1) : QUIET_MAX;
    end

    level_d = acc_next;
    quiet_d = quiet_next;

    // Conflicting sleep requests cancel each other and fall through to the
    // autonomous rules.
    if (sleep_controller_inc && !sleep_controller_dec) begin
      inc_d = 1'b1;
      if (acc_next >= THRESH) level_d = acc_next - THRESH;
    end else if (sleep_controller_dec && !sleep_controller_inc) begin
      dec_d   = 1'b1;
      quiet_d = '0;
    end else if (state_q == IDLE && acc_next >= THRESH) begin
      inc_d   = 1'b1;
      level_d = acc_next - THRESH;
    end else if (state_q == IDLE && quiet_next == QUIET_MAX) begin
      dec_d   = 1'b1;
      quiet_d = '0;
    end

    if (inc_d || dec_d) begin
      cd_d    = CD_LOAD;
      state_d = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
    end else if (state_q == COOLDOWN) begin
      // cd_q is at least 1 whenever COOLDOWN is occupied.
      cd_d = cd_q - CD_W'(1);
      if (cd_q == CD_W'(1)) state_d = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      quiet_q <= '0;
      cd_q    <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else if (tick) begin
      state_q <= state_d;
      level_q <= level_d;
      quiet_q <= quiet_d;
      cd_q    <= cd_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end else begin
      // Pulses are one clock wide even across idle clocks.
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end
  end

  assign stress_inc = inc_q;
  assign stress_dec = dec_q;
  assign level      = level_q;
  assign busy       = (state_q == COOLDOWN);

endmodule

// File: tb/tb_stress_accumulator.sv
// Testbench for stress_accumulator: a default-parameter instance and a small
// saturating instance (ACC_WIDTH=4, INC_THRESHOLD=15, COOLDOWN_TICKS=15)
// share one stimulus stream and are compared against an integer model.
module tb_stress_accumulator;

  logic       clk = 1'b0;
  logic       rst_n, tick, sci, scd;
  logic [6:0] stimuli;

  logic       inc_a, dec_a, busy_a;
  logic [7:0] level_a;
  logic       inc_b, dec_b, busy_b;
  logic [3:0] level_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stress_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .sleep_controller_inc(sci), .sleep_controller_dec(scd),
    .stimuli(stimuli),
    .stress_inc(inc_a), .stress_dec(dec_a), .level(level_a), .busy(busy_a)
  );

  stress_accumulator #(
    .NUM_STIMULI(7), .ACC_WIDTH(4), .INC_THRESHOLD(15),
    .QUIET_TICKS(8), .COOLDOWN_TICKS(15)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .sleep_controller_inc(sci), .sleep_controller_dec(scd),
    .stimuli(stimuli),
    .stress_inc(inc_b), .stress_dec(dec_b), .level(level_b), .busy(busy_b)
  );

  // Behavioural model: cooldown is simply "ticks of suppression remaining".
  typedef struct {
    int level;
    int quiet;
    int cd;
    bit inc;
    bit dec;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(input model_t s, input bit tk,
                                        input bit si, input bit sd, input int p,
                                        input int acc_max, input int th,
                                        input int qt, input int cdt);
    model_t n;
    int acc, qn;
    n = s;
    n.inc = 0;
    n.dec = 0;
    if (!tk) return n;
    if (p > 0) begin
      acc = (s.level + p > acc_max) ? acc_max : s.level + p;
      qn  = 0;
    end else begin
      acc = (s.level > 0) ? s.level - 1 : 0;
      qn  = (s.quiet + 1 > qt) ? qt : s.quiet + 1;
    end
    n.level = acc;
    n.quiet = qn;
    if (si && !sd) begin
      n.inc = 1;
      if (acc >= th) n.level = acc - th;
    end else if (sd && !si) begin
      n.dec   = 1;
      n.quiet = 0;
    end else if (s.cd == 0 && acc >= th) begin
      n.inc   = 1;
      n.level = acc - th;
    end else if (s.cd == 0 && qn == qt) begin
      n.dec   = 1;
      n.quiet = 0;
    end
    if (n.inc || n.dec) n.cd = cdt;
    else if (s.cd > 0) n.cd = s.cd - 1;
    return n;
  endfunction

  // Drive inputs, take one clk edge, advance the models, sample 1 time unit later.
  task automatic drive(input bit rn, input bit tk, input bit si, input bit sd,
                       input logic [6:0] st);
    rst_n   = rn;
    tick    = tk;
    sci     = si;
    scd     = sd;
    stimuli = st;
    @(posedge clk);
    if (!rn) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = model_step(ma, tk, si, sd, $countones(st), 255, 16, 8, 4);
      mb = model_step(mb, tk, si, sd, $countones(st), 15, 15, 8, 15);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h7F);
      checks++;
      if ({inc_a, dec_a, busy_a, level_a} !== 11'd0) begin
        failures++;
        $display("FAIL reset_a[%0d]: got inc=%b dec=%b busy=%b level=%0d, want all 0",
                 i, inc_a, dec_a, busy_a, level_a);
      end
      checks++;
      if ({inc_b, dec_b, busy_b, level_b} !== 7'd0) begin
        failures++;
        $display("FAIL reset_b[%0d]: got inc=%b dec=%b busy=%b level=%0d, want all 0",
                 i, inc_b, dec_b, busy_b, level_b);
      end
    end
  endtask

  task automatic test_autonomous_inc();
    int exp_level[9] = '{7, 14, 5, 12, 19, 26, 33, 24, 31};
    bit exp_inc[9]   = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
    bit exp_busy[9]  = '{0, 0, 1, 1, 1, 1, 0, 1, 1};
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h7F);
      checks++;
      if (level_a !== 8'(exp_level[i])) begin
        failures++;
        $display("FAIL auto_level[%0d]: got %0d want %0d", i + 1, level_a, exp_level[i]);
      end
      checks++;
      if ({inc_a, dec_a, busy_a} !== {exp_inc[i], 1'b0, exp_busy[i]}) begin
        failures++;
        $display("FAIL auto_flags[%0d]: got inc=%b dec=%b busy=%b want inc=%b dec=0 busy=%b",
                 i + 1, inc_a, dec_a, busy_a, exp_inc[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_leak_quiet_dec();
    int exp_level[8] = '{4, 3, 2, 1, 0, 0, 0, 0};
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h1F);
    checks++;
    if (level_a !== 8'd5 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL leak_setup: got level=%0d busy=%b want level=5 busy=0", level_a, busy_a);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h00);
      checks++;
      if ({inc_a, dec_a, busy_a, level_a} !== {1'b0, i == 7, i == 7, 8'(exp_level[i])}) begin
        failures++;
        $display("FAIL leak[%0d]: got inc=%b dec=%b busy=%b level=%0d want dec=%b busy=%b level=%0d",
                 i + 1, inc_a, dec_a, busy_a, level_a, i == 7, i == 7, exp_level[i]);
      end
    end
  endtask

  task automatic test_sleep_override();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h7F);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h00);          // cooldown tick 1, level 4
    drive(1'b1, 1'b1, 1'b1, 1'b0, 7'h00);          // sleep inc at cooldown tick 2
    checks++;
    if ({inc_a, dec_a, busy_a, level_a} !== {1'b1, 1'b0, 1'b1, 8'd3}) begin
      failures++;
      $display("FAIL sleep_inc: got inc=%b dec=%b busy=%b level=%0d want inc=1 dec=0 busy=1 level=3",
               inc_a, dec_a, busy_a, level_a);
    end
    // Cooldown reloaded to 4: busy for three more ticks, idle after the fourth.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h00);
      checks++;
      if ({inc_a, dec_a, busy_a} !== {1'b0, 1'b0, i != 3}) begin
        failures++;
        $display("FAIL sleep_cd[%0d]: got inc=%b dec=%b busy=%b want inc=0 dec=0 busy=%b",
                 i, inc_a, dec_a, busy_a, i != 3);
      end
    end
    // Conflicting requests are dropped.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h07);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 7'h00);
    checks++;
    if ({inc_a, dec_a, busy_a, level_a} !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
      failures++;
      $display("FAIL sleep_both: got inc=%b dec=%b busy=%b level=%0d want 0 0 0 level=2",
               inc_a, dec_a, busy_a, level_a);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 7'h00);
    checks++;
    if ({inc_a, dec_a, busy_a, level_a} !== {1'b0, 1'b1, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL sleep_dec: got inc=%b dec=%b busy=%b level=%0d want inc=0 dec=1 busy=1 level=1",
               inc_a, dec_a, busy_a, level_a);
    end
  endtask

  task automatic test_enable_gating();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h7F);
    checks++;
    if (inc_a !== 1'b1) begin
      failures++;
      $display("FAIL gate_setup: got inc=%b want 1", inc_a);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, i[0], i[1], 7'h7F);
      checks++;
      if ({inc_a, dec_a, busy_a, level_a} !== {1'b0, 1'b0, 1'b1, 8'd5}) begin
        failures++;
        $display("FAIL gate[%0d]: got inc=%b dec=%b busy=%b level=%0d want 0 0 1 level=5",
                 i, inc_a, dec_a, busy_a, level_a);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_lv;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h7F);
    checks++;
    if ({inc_b, busy_b, level_b} !== {1'b1, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL sat_first_inc: got inc=%b busy=%b level=%0d want inc=1 busy=1 level=0",
               inc_b, busy_b, level_b);
    end
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h7F);
      exp_lv = (k == 1) ? 7 : (k == 2) ? 14 : 15;
      checks++;
      if ({inc_b, dec_b, busy_b, level_b} !== {1'b0, 1'b0, k != 15, 4'(exp_lv)}) begin
        failures++;
        $display("FAIL sat_cd[%0d]: got inc=%b dec=%b busy=%b level=%0d want 0 0 %b level=%0d",
                 k, inc_b, dec_b, busy_b, level_b, k != 15, exp_lv);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 7'h7F);
    checks++;
    if ({inc_b, busy_b, level_b} !== {1'b1, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL sat_second_inc: got inc=%b busy=%b level=%0d want inc=1 busy=1 level=0",
               inc_b, busy_b, level_b);
    end
  endtask

  task automatic test_random();
    logic [6:0] st;
    bit rn, tk, si, sd;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(63) != 0);
      tk = ($urandom_range(3) != 0);
      si = ($urandom_range(9) == 0);
      sd = ($urandom_range(9) == 0);
      case ($urandom_range(3))
        0:       st = 7'h00;
        1:       st = 7'h7F;
        default: st = 7'($urandom);
      endcase
      drive(rn, tk, si, sd, st);
      checks++;
      if ({inc_a, dec_a, busy_a, level_a} !== {ma.inc, ma.dec, ma.cd > 0, 8'(ma.level)}) begin
        failures++;
        $display("FAIL rand_a[%0d]: got inc=%b dec=%b busy=%b level=%0d want inc=%b dec=%b busy=%b level=%0d",
                 i, inc_a, dec_a, busy_a, level_a, ma.inc, ma.dec, ma.cd > 0, ma.level);
      end
      checks++;
      if ({inc_b, dec_b, busy_b, level_b} !== {mb.inc, mb.dec, mb.cd > 0, 4'(mb.level)}) begin
        failures++;
        $display("FAIL rand_b[%0d]: got inc=%b dec=%b busy=%b level=%0d want inc=%b dec=%b busy=%b level=%0d",
                 i, inc_b, dec_b, busy_b, level_b, mb.inc, mb.dec, mb.cd > 0, mb.level);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    tick    = 1'b0;
    sci     = 1'b0;
    scd     = 1'b0;
    stimuli = '0;
    ma      = '{default: 0};
    mb      = '{default: 0};
    test_reset();
    test_autonomous_inc();
    test_leak_quiet_dec();
    test_sleep_override();
    test_enable_gating();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
